// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time and the rise-to-rise period of a
// servo-style PWM line sampled at 10 kHz, validates each frame against
// width/period windows, and reports width, period and a coarse position.
module servo_pwm_decoder #(
  parameter int MIN_W    = 5,
  parameter int MAX_W    = 25,
  parameter int PER_MIN  = 180,
  parameter int PER_MAX  = 220,
  parameter int LOW_MAX  = 9,
  parameter int HIGH_MIN = 15,
  parameter int TIMEOUT  = 250
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] width,
  output logic [7:0] period,
  output logic [1:0] position,
  output logic       sample_valid,
  output logic       bad_frame,
  output logic       signal_lost
);

  localparam logic [7:0] MIN_W8    = 8'(MIN_W);
  localparam logic [7:0] MAX_W8    = 8'(MAX_W);
  localparam logic [7:0] PER_MIN8  = 8'(PER_MIN);
  localparam logic [7:0] PER_MAX8  = 8'(PER_MAX);
  localparam logic [7:0] LOW_MAX8  = 8'(LOW_MAX);
  localparam logic [7:0] HIGH_MIN8 = 8'(HIGH_MIN);
  localparam logic [7:0] TIMEOUT8  = 8'(TIMEOUT);

  typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

  state_t     state, state_n;
  logic       sync1, s, s_d;
  logic       rise, fall;
  logic [7:0] hi_cnt, per_cnt, hi_n, per_n;
  logic       frame_done, frame_ok, loss;
  logic [1:0] pos_calc;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // State and counter registers
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state   <= ARM;
      hi_cnt  <= 8'd0;
      per_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      hi_cnt  <= hi_n;
      per_cnt <= per_n;
    end
  end

  // Next-state and counter logic; a rise always wins over a timeout
  always_comb begin
    state_n    = state;
    hi_n       = hi_cnt;
    per_n      = per_cnt;
    frame_done = 1'b0;
    loss       = 1'b0;
    case (state)
      ARM: begin
        if (rise) begin
          state_n = HIGH;
          hi_n    = 8'd1;
          per_n   = 8'd1;
        end
      end
      HIGH: begin
        if (hi_cnt >= TIMEOUT8) begin
          loss    = 1'b1;
          state_n = ARM;
          hi_n    = 8'd0;
          per_n   = 8'd0;
        end else begin
          per_n = sat_inc(per_cnt);
          if (fall) state_n = LOW;
          else      hi_n    = sat_inc(hi_cnt);
        end
      end
      LOW: begin
        if (rise) begin
          frame_done = 1'b1;
          state_n    = HIGH;
          hi_n       = 8'd1;
          per_n      = 8'd1;
        end else if (per_cnt >= TIMEOUT8) begin
          loss    = 1'b1;
          state_n = ARM;
          hi_n    = 8'd0;
          per_n   = 8'd0;
        end else begin
          per_n = sat_inc(per_cnt);
        end
      end
      default: state_n = ARM;
    endcase
  end

  // Frame validation and position bucketing from the captured counts
  always_comb begin
    frame_ok = (hi_cnt >= MIN_W8) && (hi_cnt <= MAX_W8) &&
               (per_cnt >= PER_MIN8) && (per_cnt <= PER_MAX8);
    if (hi_cnt <= LOW_MAX8)       pos_calc = 2'd0;
    else if (hi_cnt >= HIGH_MIN8) pos_calc = 2'd2;
    else                          pos_calc = 2'd1;
  end

  // Output registers: latch valid frames, strobe results, flag loss
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      width        <= 8'd0;
      period       <= 8'd0;
      position     <= 2'd3;
      sample_valid <= 1'b0;
      bad_frame    <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      bad_frame    <= 1'b0;
      if (frame_done) begin
        if (frame_ok) begin
          width        <= hi_cnt;
          period       <= per_cnt;
          position     <= pos_calc;
          sample_valid <= 1'b1;
          signal_lost  <= 1'b0;
        end else begin
          bad_frame <= 1'b1;
        end
      end
      if (loss) begin
        signal_lost <= 1'b1;
        position    <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder: directed PWM frames, an event-time model of
// the decoder compared every cycle, plus literal checks at phase boundaries.
module tb_servo_pwm_decoder;

  localparam int TIMEOUT = 250;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic       pwm_in    = 1'b0;
  logic [7:0] width, period;
  logic [1:0] position;
  logic       sample_valid, bad_frame, signal_lost;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0;
  int bf_cnt = 0;

  servo_pwm_decoder dut (
    .clk_10KHz    (clk_10KHz),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .width        (width),
    .period       (period),
    .position     (position),
    .sample_valid (sample_valid),
    .bad_frame    (bad_frame),
    .signal_lost  (signal_lost)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: records the cycle numbers of synchronized rises/falls and derives
  // the frame width and period as differences between those timestamps.
  int m_ff1 = 0, m_s = 0, m_sd = 0;
  int cyc = 0, last_rise = 0, last_fall = 0;
  bit trk = 0;
  int e_w = 0, e_p = 0, e_pos = 3, e_sv = 0, e_bf = 0, e_lost = 1;

  task automatic model_step();
    int pw, pp;
    if (reset) begin
      m_ff1 = 0; m_s = 0; m_sd = 0; trk = 0; cyc = 0;
      e_w = 0; e_p = 0; e_pos = 3; e_sv = 0; e_bf = 0; e_lost = 1;
    end else begin
      cyc++;
      e_sv = 0; e_bf = 0;
      if (m_s == 1 && m_sd == 0) begin
        if (trk) begin
          pw = last_fall - last_rise;
          pp = cyc - last_rise;
          if (pw >= 5 && pw <= 25 && pp >= 180 && pp <= 220) begin
            e_w = pw; e_p = pp; e_sv = 1; e_lost = 0;
            e_pos = (pw <= 9) ? 0 : (pw >= 15) ? 2 : 1;
          end else begin
            e_bf = 1;
          end
        end
        trk = 1;
        last_rise = cyc;
      end else if (trk) begin
        if (cyc - last_rise >= TIMEOUT) begin
          trk = 0; e_lost = 1; e_pos = 3;
        end else if (m_s == 0 && m_sd == 1) begin
          last_fall = cyc;
        end
      end
      m_sd = m_s; m_s = m_ff1; m_ff1 = int'(pwm_in);
    end
  endtask

  initial forever begin
    @(posedge clk_10KHz);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk_10KHz);
    if (!reset) begin
      chk("width",        int'(width),        e_w);
      chk("period",       int'(period),       e_p);
      chk("position",     int'(position),     e_pos);
      chk("sample_valid", int'(sample_valid), e_sv);
      chk("bad_frame",    int'(bad_frame),    e_bf);
      chk("signal_lost",  int'(signal_lost),  e_lost);
      chk("strobe_excl",  int'(sample_valid & bad_frame), 0);
      if (sample_valid) sv_cnt++;
      if (bad_frame)    bf_cnt++;
    end
  end

  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk_10KHz);
    #1;
  endtask

  task automatic frames(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_width",    int'(width),        0);
    chk("rst_period",   int'(period),       0);
    chk("rst_position", int'(position),     3);
    chk("rst_sv",       int'(sample_valid), 0);
    chk("rst_bf",       int'(bad_frame),    0);
    chk("rst_lost",     int'(signal_lost),  1);
  endtask

  task automatic chk_out(input string tag, input int w, input int p, input int pos, input int lost);
    chk({tag, "_width"},    int'(width),       w);
    chk({tag, "_period"},   int'(period),      p);
    chk({tag, "_position"}, int'(position),    pos);
    chk({tag, "_lost"},     int'(signal_lost), lost);
  endtask

  initial begin
    int sv0, bf0;
    repeat (3) @(negedge clk_10KHz);
    #1;
    chk_reset_vals();
    reset = 1'b0;
    hold(1'b0, 5);

    // 7/200: first rise silent, strobes on rises 2..4
    frames(7, 200, 4);
    chk("p1_sv_count", sv_cnt, 3);
    chk_out("p1", 7, 200, 0, 0);

    // 12/200 then 17/200
    frames(12, 200, 2);
    chk_out("p2a", 12, 200, 1, 0);
    frames(17, 200, 2);
    chk_out("p2b", 17, 200, 2, 0);
    chk("p2_bf_count", bf_cnt, 0);

    // short pulse inside a valid stream
    frames(12, 200, 1);
    bf0 = bf_cnt;
    frames(3, 200, 1);
    frames(17, 200, 1);
    chk("p3_bf_delta", bf_cnt - bf0, 1);
    chk_out("p3", 12, 200, 1, 0);

    // period 150: the first rise still closes the last 17/200 frame
    sv0 = sv_cnt; bf0 = bf_cnt;
    frames(12, 150, 4);
    chk("p4_sv_delta", sv_cnt - sv0, 1);
    chk("p4_bf_delta", bf_cnt - bf0, 3);
    chk_out("p4", 17, 200, 2, 0);

    // line held low: loss, then recovery on the second rise
    sv0 = sv_cnt;
    hold(1'b0, 300);
    chk_out("p5_loss", 17, 200, 3, 1);
    frames(7, 200, 1);
    chk("p5_no_strobe", sv_cnt - sv0, 0);
    frames(7, 200, 2);
    chk_out("p5_rec", 7, 200, 0, 0);

    // stuck high
    hold(1'b1, 300);
    chk_out("p6_stuck", 7, 200, 3, 1);

    // reset in the middle of a pulse
    hold(1'b0, 100);
    hold(1'b1, 3);
    reset = 1'b1;
    hold(1'b1, 2);
    chk_reset_vals();
    reset = 1'b0;
    hold(1'b1, 3);
    hold(1'b0, 197);
    frames(7, 200, 1);
    chk("p7_partial_lost", int'(signal_lost), 1);
    frames(7, 200, 2);
    chk_out("p7_rec", 7, 200, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
